// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and word type for the 36-bit x 512 FIFO and
// its read-side master.
//   DATA_W          FIFO word width
//   FIFO_DEPTH      FIFO entries
//   FIFO_PTR_W      FIFO address width
//   FIFO_RD_LATENCY cycles from read strobe to valid read data
package fifo_pkg;
  localparam int DATA_W          = 36;
  localparam int FIFO_DEPTH      = 512;
  localparam int FIFO_PTR_W      = 9;
  localparam int FIFO_RD_LATENCY = 1;

  typedef logic [DATA_W-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry valid/ready buffer, FIFO ordered.
// The writer has no back-pressure input; it must use occ as read credit so
// a write never lands on a full buffer.
//   rd_clk     clock
//   rst        synchronous active-low reset
//   in_valid   write strobe
//   in_data    write word
//   out_valid  head entry present
//   out_ready  downstream accept
//   out_data   head entry
//   occ        entries held, 0..2
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         rd_clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              pop;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign occ       = cnt;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge rd_clk) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (in_valid) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // write + pop together leaves the count unchanged
      case ({in_valid, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/fifo_36bit_reader.sv
// fifo_36bit_reader: read-side master for the 36-bit x 512 FIFO. Pops words
// (1-cycle read latency) into a 2-entry skid buffer and presents them as a
// valid/ready stream, marking every PKT_WORDS-th word with m_last.
// Optional statistics counters are built when FIFO_READER_STATS_EN is
// defined; otherwise stat_words/stat_stalls are tied to 0.
//   rd_clk        clock (FIFO read domain)
//   rst           synchronous active-low reset
//   en            1 = issue reads; 0 = stop reading, drain normally
//   fifo_rd_en    FIFO read strobe
//   fifo_rd_data  FIFO read data, valid the cycle after a read
//   fifo_empty    FIFO empty flag
//   m_valid/m_ready/m_data/m_last  output stream
//   busy          read in flight or word buffered
//   stat_words    accepted-word count
//   stat_stalls   cycles with m_valid & ~m_ready
module fifo_36bit_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = fifo_pkg::DATA_W,
  parameter int PKT_WORDS = 4
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [31:0]       stat_words,
  output logic [31:0]       stat_stalls
);
  localparam logic [15:0] LAST_BEAT = 16'(PKT_WORDS - 1);

  logic        inflight;
  logic [1:0]  occ;
  logic        pop;
  logic [2:0]  committed;
  logic        credit_ok;
  logic [15:0] beat;

  assign pop = m_valid & m_ready;

  // Words already owed to the buffer must fit after this cycle's pop.
  assign committed  = {1'b0, occ} + {2'b0, inflight};
  assign credit_ok  = committed < (3'd2 + {2'b0, pop});
  assign fifo_rd_en = rst & en & ~fifo_empty & credit_ok;

  always_ff @(posedge rd_clk) begin
    if (!rst) inflight <= 1'b0;
    else      inflight <= fifo_rd_en;
  end

  fifo_skid_buf #(.W(DATA_W)) u_skid (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   (fifo_rd_data),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .occ       (occ)
  );

  always_ff @(posedge rd_clk) begin
    if (!rst)     beat <= 16'd0;
    else if (pop) beat <= (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
  end

  assign m_last = m_valid & (beat == LAST_BEAT);
  assign busy   = inflight | (occ != 2'd0);

`ifdef FIFO_READER_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stalls_q;

  always_ff @(posedge rd_clk) begin
    if (!rst) begin
      words_q  <= 32'd0;
      stalls_q <= 32'd0;
    end else begin
      if (pop)                 words_q  <= words_q + 32'd1;
      if (m_valid && !m_ready) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_words  = 32'd0;
  assign stat_stalls = 32'd0;
`endif
endmodule

// File: tb/tb_fifo_36bit_reader.sv
// tb_fifo_36bit_reader: directed bench for fifo_36bit_reader with a
// behavioural FIFO and a word-level reference model checked every cycle.
module tb_fifo_36bit_reader;
  localparam int PKT = 4;

  logic        rd_clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        fifo_rd_en;
  logic [35:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [35:0] m_data;
  logic        m_last;
  logic        busy;
  logic [31:0] stat_words;
  logic [31:0] stat_stalls;

  fifo_36bit_reader #(.DATA_W(36), .PKT_WORDS(PKT)) dut (
    .rd_clk       (rd_clk),
    .rst          (rst),
    .en           (en),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .stat_words   (stat_words),
    .stat_stalls  (stat_stalls)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct { logic [35:0] word; int cyc; } ent_t;
  typedef struct { logic [35:0] data; bit last; int cyc; } pop_t;

  logic [35:0] fq[$];      // FIFO contents
  ent_t        exp_q[$];   // words read and not yet accepted, with issue cycle
  pop_t        log_q[$];   // accepted words
  int          rd_log[$];  // read issue cycles

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          beat_m = 0;
  int          words_m = 0;
  int          stalls_m = 0;
  bit          rst_at_edge = 1'b0;
  bit          s_rd_en = 1'b0;
  int          base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO behaviour: data of a read appears just after the next edge
  always @(posedge rd_clk) begin
    #1;
    if (s_rd_en && fq.size() > 0) fifo_rd_data = fq.pop_front();
    else                          fifo_rd_data = 36'hBADBADBAD;
    fifo_empty = (fq.size() == 0);
  end

  // Reference model and per-cycle compare
  always @(negedge rd_clk) begin
    int  pending;
    bit  ev;
    bit  pop;
    bit  erd;
    cyc++;
    if (!rst_at_edge) begin
      exp_q.delete();
      beat_m = 0; words_m = 0; stalls_m = 0;
      chk("reset_m_data", m_data, 0);
      chk("reset_m_last", m_last, 0);
    end
    pending = 0;
    foreach (exp_q[i]) if (exp_q[i].cyc <= cyc - 1) pending++;
    ev = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2);
    chk("m_valid", m_valid, ev);
    chk("busy", busy, pending != 0);
    chk("occ_le_2", pending <= 2, 1);
    if (ev) begin
      chk("m_data", m_data, exp_q[0].word);
      chk("m_last", m_last, beat_m == PKT - 1);
    end
    pop = ev && m_ready;
    erd = rst && en && !fifo_empty && (pending - int'(pop) < 2);
    chk("fifo_rd_en", fifo_rd_en, erd);
`ifdef FIFO_READER_STATS_EN
    chk("stat_words", stat_words, words_m);
    chk("stat_stalls", stat_stalls, stalls_m);
`else
    chk("stat_words", stat_words, 0);
    chk("stat_stalls", stat_stalls, 0);
`endif
    if (fifo_rd_en && fq.size() > 0) begin
      exp_q.push_back('{fq[0], cyc});
      rd_log.push_back(cyc);
    end
    s_rd_en = fifo_rd_en;
    if (pop) begin
      log_q.push_back('{exp_q[0].word, beat_m == PKT - 1, cyc});
      void'(exp_q.pop_front());
      beat_m = (beat_m == PKT - 1) ? 0 : beat_m + 1;
      words_m++;
    end
    if (ev && !m_ready) stalls_m++;
    rst_at_edge = rst;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; m_ready = 1'b0;
    fq.delete(); fifo_empty = 1'b1;
    tick(2);
    log_q.delete(); rd_log.delete();
  endtask

  task automatic load(input logic [35:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + 36'(i));
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic start(input bit rdy);
    m_ready = rdy; en = 1'b1; rst = 1'b1;
    base = cyc + 1;
  endtask

  initial begin
    // reset hold with data available and reads enabled
    fq.push_back(36'h123); fifo_empty = 1'b0; en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("hold_rd_en", fifo_rd_en, 0);
      chk("hold_m_valid", m_valid, 0);
      chk("hold_busy", busy, 0);
    end

    // streaming
    do_reset(); load(36'h1, 8); start(1'b1);
    tick(14);
    chk("stream_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("stream_data", log_q[i].data, 36'(i + 1));
      chk("stream_last", log_q[i].last, (i == 3) || (i == 7));
      chk("stream_cycle", log_q[i].cyc - base, i + 2);
    end

    // backpressure
    do_reset(); load(36'h1, 8); start(1'b0);
    tick(10);
    chk("bp_reads", rd_log.size(), 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_hold_data", m_data, 36'h1);
    m_ready = 1'b1;
    tick(14);
    chk("bp_count", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk("bp_data", log_q[i].data, 36'(i + 1));

    // single word then empty
    do_reset(); load(36'hFFFFFFFFF, 1); start(1'b1);
    tick(8);
    chk("empty_reads", rd_log.size(), 1);
    chk("empty_count", log_q.size(), 1);
    if (log_q.size() > 0) chk("empty_data", log_q[0].data, 36'hFFFFFFFFF);
    chk("empty_rd_en", fifo_rd_en, 0);

    // en drop after three reads, then re-enable
    do_reset(); load(36'h11, 8); start(1'b1);
    tick(3); en = 1'b0;
    tick(8);
    chk("endrop_reads", rd_log.size(), 3);
    chk("endrop_count", log_q.size(), 3);
    chk("endrop_busy", busy, 0);
    en = 1'b1;
    tick(4);
    chk("reen_count_ge4", log_q.size() >= 4, 1);
    if (log_q.size() >= 4) begin
      chk("reen_data", log_q[3].data, 36'h14);
      chk("reen_last", log_q[3].last, 1);
    end
    en = 1'b0;
    tick(6);

    // statistics: 4 stall cycles then 6 pops
    do_reset(); load(36'h21, 6); start(1'b0);
    tick(6); m_ready = 1'b1;
    tick(12);
    chk("stats_count", log_q.size(), 6);
`ifdef FIFO_READER_STATS_EN
    chk("stats_words_lit", stat_words, 6);
    chk("stats_stalls_lit", stat_stalls, 4);
`else
    chk("stats_words_lit", stat_words, 0);
    chk("stats_stalls_lit", stat_stalls, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_36bit_reader.md
Name: fifo_36bit_reader

Overview:
- Read-side master for the 36-bit x 512 FIFO.
- Pops words from the FIFO read port (1-cycle read latency) and presents them as a valid/ready stream to downstream path-tracer stages (ray/hit consumers).
- Absorbs downstream backpressure with a 2-entry skid buffer and never issues a read the buffer cannot hold.
- Marks packet boundaries with m_last every PKT_WORDS words.

Parameters:
- DATA_W, 36, word width; must match the FIFO word size.
- PKT_WORDS, 4, words per packet; m_last on the final word; legal range 1..65535.

Ports:
- rd_clk  in  1  sole clock; FIFO read-side clock domain.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rd_clk rising edge).
- en  in  1  1 = issue FIFO reads; 0 = stop new reads, drain in-flight/buffered words normally.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  DATA_W  FIFO read data, valid one cycle after an accepted read.
- fifo_empty  in  1  FIFO empty flag.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  output word.
- m_last  out  1  last word of packet; qualified by m_valid.
- busy  out  1  in-flight read or buffered word present.
- stat_words  out  32  accepted-word counter (see Optional Feature).
- stat_stalls  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (rst=0) forces the following on the next edge: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, busy=0, occupancy=0, inflight=0, beat counter=0, stats=0.
- Reset mid-operation discards buffered and in-flight words. Data returned in the cycle after reset is ignored.
- Definitions:
  - occ: buffer entries, 0..2.
  - inflight: 1 if fifo_rd_en was asserted last cycle.
  - pop: m_valid & m_ready.
- Read issue is combinational: fifo_rd_en = en & ~fifo_empty & (occ + inflight - pop < 2). It is never asserted while fifo_empty=1.
- Read latency: a read issued in cycle N writes fifo_rd_data into the buffer at the end of cycle N+1. Earliest m_valid is cycle N+2.
- Buffer rules:
  - FIFO order is preserved.
  - m_valid = (occ != 0).
  - m_data and m_last come from the head entry.
  - Simultaneous write and pop in the same cycle leave occ unchanged.
  - The buffer never overflows; the bench asserts occ <= 2 always.
- Output stability: while m_valid=1 and m_ready=0, m_data and m_last hold constant.
- Sustained throughput: 1 word/cycle when the FIFO is non-empty and m_ready=1 continuously.
- Beat counter:
  - Width 16 bits; increments on pop.
  - Wraps to 0 after value PKT_WORDS-1.
  - m_last = (beat == PKT_WORDS-1).
  - PKT_WORDS=1 gives m_last=1 on every word.
- en deassert: no new reads from the next cycle. The in-flight word still lands and all buffered words still drain. Beat counter is not reset.
- busy = inflight | (occ != 0).
- FIFO wrap-around: not visible here; ordering only is checked.

Optional Feature:
- Macro: FIFO_READER_STATS_EN.
- Defined:
  - stat_words increments on each pop.
  - stat_stalls increments on each cycle with m_valid & ~m_ready.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined:
  - Both ports are tied to 0.
  - No counter flops are synthesised.

Decomposition:
- Package fifo_pkg holds:
  - DATA_W=36.
  - FIFO_DEPTH=512.
  - FIFO_PTR_W=9.
  - FIFO_RD_LATENCY=1.
  - Typedef fifo_word_t (DATA_W bits).
- Sub-module fifo_skid_buf: 2-entry valid/ready buffer with in_valid/in_data and out_valid/out_ready/out_data, plus an occ output used for read credit.
- Top level holds read issue, inflight flag, beat counter and stats.

Test Plan:
- Reset hold: rst=0 for 3 cycles with fifo_empty=0, en=1 -> fifo_rd_en=0, m_valid=0, busy=0 throughout.
- Streaming: FIFO preloaded 0x000000001..0x000000008, m_ready=1, en=1 from cycle 0 -> first m_valid at cycle 2, eight words on consecutive cycles in order, m_last on words 4 and 8.
- Backpressure: 8 words preloaded, m_ready=0 for cycles 2..9 -> fifo_rd_en stops after 2 reads, m_data stays 0x000000001 stable. Release m_ready -> all 8 words delivered, no loss or duplication, occ never >2.
- Empty boundary: single word 0xFFFFFFFFF, then fifo_empty=1 -> exactly one read, one output word, fifo_rd_en stays 0 while empty.
- en drop mid-stream: deassert en after 3 reads issued -> exactly 3 words output, busy falls after the last pop. Re-enable -> the next word has m_last (beat=3).
- Stats (macro defined): 6 pops with 4 stall cycles -> stat_words=6, stat_stalls=4. Macro undefined -> both read 0.
